// File: rtl/phy_8b10b_decoder_if.sv
// Symbol/result bundle between the PHY receive path and the 8b10b decoder.
// master: the side that feeds symbols and consumes decode results.
// slave:  the decoder itself.
interface phy_8b10b_decoder_if #(
  parameter int ERR_CNT_W = 8
);
  logic                 sym_valid;
  logic [9:0]           sym_in;
  logic                 err_clr;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic [3:0]           out_sel;
  logic                 code_err;
  logic                 disp_err;
  logic                 frame_err;
  logic                 in_pkt;
  logic                 rd_pos;
  logic [ERR_CNT_W-1:0] err_cnt;

  modport master (
    output sym_valid, sym_in, err_clr,
    input  out_valid, out_data, out_sel, code_err, disp_err, frame_err,
           in_pkt, rd_pos, err_cnt
  );

  modport slave (
    input  sym_valid, sym_in, err_clr,
    output out_valid, out_data, out_sel, code_err, disp_err, frame_err,
           in_pkt, rd_pos, err_cnt
  );
endinterface

// File: rtl/phy_8b10b_decoder.sv
// Receive-side 8b10b decoder: comma/data classification, running disparity
// tracking, START..END packet framing and a saturating error counter.
// One registered cycle of latency, no backpressure.
module phy_8b10b_decoder #(
  parameter int ERR_CNT_W = 8
) (
  input logic               CLK,
  input logic               nRST,
  phy_8b10b_decoder_if.slave bus
);

  // comma_sel_t encoding; the eight commas use their table index directly
  localparam logic [3:0] START_PACKET_SEL   = 4'd0;
  localparam logic [3:0] END_PACKET_SEL     = 4'd1;
  localparam logic [3:0] RESEND_PACKET0_SEL = 4'd2;
  localparam logic [3:0] RESEND_PACKET1_SEL = 4'd3;
  localparam logic [3:0] RESEND_PACKET2_SEL = 4'd4;
  localparam logic [3:0] RESEND_PACKET3_SEL = 4'd5;
  localparam logic [3:0] ACK_SEL            = 4'd6;
  localparam logic [3:0] NACK_SEL           = 4'd7;
  localparam logic [3:0] DATA_SEL           = 4'd8;
  localparam logic [3:0] NADA_SEL           = 4'd9;

  // Framer states
  localparam logic [0:0] IDLE   = 1'b0;
  localparam logic [0:0] IN_PKT = 1'b1;

  // Link commas K28.0..K28.7 in their RD- form; the RD+ form is the complement
  function automatic logic [9:0] comma_code(input logic [2:0] idx);
    case (idx)
      3'd0:    comma_code = 10'b0011110100;
      3'd1:    comma_code = 10'b0011111001;
      3'd2:    comma_code = 10'b0011110101;
      3'd3:    comma_code = 10'b0011110011;
      3'd4:    comma_code = 10'b0011110010;
      3'd5:    comma_code = 10'b0011111010;
      3'd6:    comma_code = 10'b0011110110;
      default: comma_code = 10'b0011111000;
    endcase
  endfunction

  // 5b/6b table, RD+ form (000111 is the RD+ form of the balanced D.7)
  function automatic logic [5:0] code6(input logic [4:0] idx);
    case (idx)
      5'd0:  code6 = 6'b011000;  5'd1:  code6 = 6'b100010;
      5'd2:  code6 = 6'b010010;  5'd3:  code6 = 6'b110001;
      5'd4:  code6 = 6'b001010;  5'd5:  code6 = 6'b101001;
      5'd6:  code6 = 6'b011001;  5'd7:  code6 = 6'b000111;
      5'd8:  code6 = 6'b000110;  5'd9:  code6 = 6'b100101;
      5'd10: code6 = 6'b010101;  5'd11: code6 = 6'b110100;
      5'd12: code6 = 6'b001101;  5'd13: code6 = 6'b101100;
      5'd14: code6 = 6'b011100;  5'd15: code6 = 6'b101000;
      5'd16: code6 = 6'b100100;  5'd17: code6 = 6'b100011;
      5'd18: code6 = 6'b010011;  5'd19: code6 = 6'b110010;
      5'd20: code6 = 6'b001011;  5'd21: code6 = 6'b101010;
      5'd22: code6 = 6'b011010;  5'd23: code6 = 6'b000101;
      5'd24: code6 = 6'b001100;  5'd25: code6 = 6'b100110;
      5'd26: code6 = 6'b010110;  5'd27: code6 = 6'b001001;
      5'd28: code6 = 6'b001110;  5'd29: code6 = 6'b010001;
      5'd30: code6 = 6'b100001;  default: code6 = 6'b010100;
    endcase
  endfunction

  // 3b/4b table, RD+ form
  function automatic logic [3:0] code4(input logic [2:0] idx);
    case (idx)
      3'd0:    code4 = 4'b0100;
      3'd1:    code4 = 4'b1001;
      3'd2:    code4 = 4'b0101;
      3'd3:    code4 = 4'b0011;
      3'd4:    code4 = 4'b0010;
      3'd5:    code4 = 4'b1010;
      3'd6:    code4 = 4'b0110;
      default: code4 = 4'b0001;
    endcase
  endfunction

  logic [5:0]           sym6;
  logic [3:0]           sym4;
  logic [2:0]           ones6;
  logic [2:0]           ones4;
  logic                 is_comma;
  logic [2:0]           comma_idx;
  logic                 hit6;
  logic [4:0]           val6;
  logic                 hit4;
  logic [2:0]           val4;
  logic [5:0]           c6;
  logic [3:0]           c4;
  logic                 rd_mid;
  logic                 rd_nxt;
  logic                 nxt_disp_err;
  logic                 nxt_valid;
  logic [3:0]           nxt_sel;
  logic [7:0]           nxt_data;
  logic                 nxt_code_err;
  logic                 nxt_frame_err;
  logic [0:0]           nxt_state;
  logic                 any_err;

  logic                 out_valid_q;
  logic [7:0]           out_data_q;
  logic [3:0]           out_sel_q;
  logic                 code_err_q;
  logic                 disp_err_q;
  logic                 frame_err_q;
  logic [0:0]           state_q;
  logic                 rd_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  assign sym6  = bus.sym_in[9:4];
  assign sym4  = bus.sym_in[3:0];
  assign ones6 = 3'($countones(sym6));
  assign ones4 = 3'($countones(sym4));

  // Comma match: either disparity form of any of the eight commas
  always_comb begin
    is_comma  = 1'b0;
    comma_idx = '0;
    for (int i = 0; i < 8; i++) begin
      if (bus.sym_in == comma_code(3'(i)) || bus.sym_in == ~comma_code(3'(i))) begin
        is_comma  = 1'b1;
        comma_idx = 3'(i);
      end
    end
  end

  // 6b lookup; balanced codes other than D.7 have a single legal form
  always_comb begin
    hit6 = 1'b0;
    val6 = '0;
    c6   = '0;
    for (int i = 0; i < 32; i++) begin
      c6 = code6(5'(i));
      if (sym6 == c6 ||
          (sym6 == ~c6 && ($countones(c6) != 3 || c6 == 6'b000111))) begin
        hit6 = 1'b1;
        val6 = 5'(i);
      end
    end
  end

  // 4b lookup including the alternate D.x.7 forms
  always_comb begin
    hit4 = 1'b0;
    val4 = '0;
    c4   = '0;
    for (int i = 0; i < 8; i++) begin
      c4 = code4(3'(i));
      if (sym4 == c4 ||
          (sym4 == ~c4 && ($countones(c4) != 2 || c4 == 4'b0011))) begin
        hit4 = 1'b1;
        val4 = 3'(i);
      end
    end
    if (sym4 == 4'b1000 || sym4 == 4'b0111) begin
      hit4 = 1'b1;
      val4 = 3'd7;
    end
  end

  // Running disparity: 6b against incoming RD, 4b against post-6b RD; RD
  // follows every unbalanced sub-block even on a violation so we resync
  always_comb begin
    nxt_disp_err = 1'b0;
    rd_mid       = rd_q;
    if (ones6 == 3'd4) begin
      nxt_disp_err = rd_q;
      rd_mid       = 1'b1;
    end else if (ones6 == 3'd2) begin
      nxt_disp_err = !rd_q;
      rd_mid       = 1'b0;
    end
    rd_nxt = rd_mid;
    if (ones4 == 3'd3) begin
      if (rd_mid) nxt_disp_err = 1'b1;
      rd_nxt = 1'b1;
    end else if (ones4 == 3'd1) begin
      if (!rd_mid) nxt_disp_err = 1'b1;
      rd_nxt = 1'b0;
    end
  end

  // Classification and framing; data outside a packet is dropped
  always_comb begin
    nxt_valid     = 1'b1;
    nxt_sel       = NADA_SEL;
    nxt_data      = '0;
    nxt_code_err  = 1'b0;
    nxt_frame_err = 1'b0;
    nxt_state     = state_q;
    if (is_comma) begin
      nxt_sel = {1'b0, comma_idx};
      if (nxt_sel == START_PACKET_SEL) begin
        nxt_frame_err = (state_q == IN_PKT);
        nxt_state     = IN_PKT;
      end else if (nxt_sel == END_PACKET_SEL) begin
        nxt_frame_err = (state_q == IDLE);
        nxt_state     = IDLE;
      end
    end else if (hit6 && hit4) begin
      nxt_sel  = DATA_SEL;
      nxt_data = {val4, val6};
      if (state_q == IDLE) begin
        nxt_frame_err = 1'b1;
        nxt_valid     = 1'b0;
      end
    end else begin
      nxt_code_err = 1'b1;
    end
  end

  assign any_err = nxt_code_err | nxt_disp_err | nxt_frame_err;

  // Output/state registers; flags pulse for one cycle per accepted symbol
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sel_q   <= NADA_SEL;
      code_err_q  <= 1'b0;
      disp_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      state_q     <= IDLE;
      rd_q        <= 1'b0;
      err_cnt_q   <= '0;
    end else begin
      out_valid_q <= 1'b0;
      code_err_q  <= 1'b0;
      disp_err_q  <= 1'b0;
      frame_err_q <= 1'b0;
      if (bus.sym_valid) begin
        out_valid_q <= nxt_valid;
        out_data_q  <= nxt_data;
        out_sel_q   <= nxt_sel;
        code_err_q  <= nxt_code_err;
        disp_err_q  <= nxt_disp_err;
        frame_err_q <= nxt_frame_err;
        state_q     <= nxt_state;
        rd_q        <= rd_nxt;
      end
      if (bus.err_clr) begin
        err_cnt_q <= '0;
      end else if (bus.sym_valid && any_err && err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = out_sel_q;
  assign bus.code_err  = code_err_q;
  assign bus.disp_err  = disp_err_q;
  assign bus.frame_err = frame_err_q;
  assign bus.in_pkt    = (state_q == IN_PKT);
  assign bus.rd_pos    = rd_q;
  assign bus.err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_phy_8b10b_decoder.sv
// Bench for phy_8b10b_decoder: directed symbols, a lookup-table reference
// model built from the RD- code forms, a per-cycle compare process and
// literal expectations at the interesting points.
module tb_phy_8b10b_decoder;

  localparam int ERR_CNT_W = 8;
  localparam int CNT_MAX   = (1 << ERR_CNT_W) - 1;
  localparam logic [3:0] DATA_SEL = 4'd8;
  localparam logic [3:0] NADA_SEL = 4'd9;

  logic CLK = 1'b0;
  logic nRST;

  phy_8b10b_decoder_if #(.ERR_CNT_W(ERR_CNT_W)) bus ();

  phy_8b10b_decoder #(.ERR_CNT_W(ERR_CNT_W)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  // 10 ns clock
  always #5 CLK = ~CLK;

  // Reference tables in the RD- (positive-disparity-first) form
  logic [5:0] rdm6 [32] = '{
    6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
    6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
    6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
    6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011};
  logic [3:0] rdm4 [8] = '{
    4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110};
  logic [9:0] commas [8] = '{
    10'b0011110100, 10'b0011111001, 10'b0011110101, 10'b0011110011,
    10'b0011110010, 10'b0011111010, 10'b0011110110, 10'b0011111000};

  int map6 [logic [5:0]];
  int map4 [logic [3:0]];

  // Model state and expected outputs
  int         m_rd;
  bit         m_in_pkt;
  int         m_cnt;
  bit         e_valid, e_code, e_disp, e_frame, e_payload;
  logic [7:0] e_data;
  logic [3:0] e_sel;
  bit         check_en = 1'b0;

  int checks   = 0;
  int failures = 0;

  // Accepted sub-block forms -> decoded value
  task automatic build_maps();
    logic [5:0] c6;
    logic [3:0] c4;
    for (int i = 0; i < 32; i++) begin
      c6 = rdm6[i];
      map6[c6] = i;
      if ($countones(c6) != 3 || i == 7) map6[~c6] = i;
    end
    for (int i = 0; i < 8; i++) begin
      c4 = rdm4[i];
      map4[c4] = i;
      if ($countones(c4) != 2 || i == 3) map4[~c4] = i;
    end
    map4[4'b0111] = 7;
    map4[4'b1000] = 7;
  endtask

  // Apply one sub-block disparity to the model's running disparity
  task automatic sub_disp(input int d);
    if (d == 2) begin
      if (m_rd > 0) e_disp = 1'b1;
      m_rd = 1;
    end else if (d == -2) begin
      if (m_rd < 0) e_disp = 1'b1;
      m_rd = -1;
    end
  endtask

  // Advance the model by one clock edge
  task automatic model_step(input bit rst_n, input bit valid, input logic [9:0] s, input bit clr);
    int cidx;
    logic [5:0] s6;
    logic [3:0] s4;
    if (!rst_n) begin
      m_rd = -1; m_in_pkt = 1'b0; m_cnt = 0;
      e_valid = 1'b0; e_code = 1'b0; e_disp = 1'b0; e_frame = 1'b0;
      e_data = 8'h00; e_sel = NADA_SEL; e_payload = 1'b1;
      return;
    end
    e_valid = 1'b0; e_code = 1'b0; e_disp = 1'b0; e_frame = 1'b0; e_payload = 1'b0;
    if (valid) begin
      s6 = s[9:4];
      s4 = s[3:0];
      sub_disp(2 * $countones(s6) - 6);
      sub_disp(2 * $countones(s4) - 4);
      cidx = -1;
      for (int k = 0; k < 8; k++)
        if (s == commas[k] || s == ~commas[k]) cidx = k;
      e_valid = 1'b1;
      if (cidx >= 0) begin
        e_sel  = 4'(cidx);
        e_data = 8'h00;
        if (cidx == 0) begin
          if (m_in_pkt) e_frame = 1'b1;
          m_in_pkt = 1'b1;
        end else if (cidx == 1) begin
          if (!m_in_pkt) e_frame = 1'b1;
          m_in_pkt = 1'b0;
        end
      end else if (map6.exists(s6) && map4.exists(s4)) begin
        e_sel  = DATA_SEL;
        e_data = 8'(map4[s4] * 32 + map6[s6]);
        if (!m_in_pkt) begin
          e_frame = 1'b1;
          e_valid = 1'b0;
        end
      end else begin
        e_code = 1'b1;
        e_sel  = NADA_SEL;
        e_data = 8'h00;
      end
      e_payload = e_valid;
    end
    if (clr) m_cnt = 0;
    else if (valid && (e_code || e_disp || e_frame) && m_cnt < CNT_MAX) m_cnt++;
  endtask

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Drive one cycle of inputs, step the model on the edge, settle 1 ns
  task automatic apply_stimulus(input bit rst_n, input bit valid, input logic [9:0] s, input bit clr);
    nRST          = rst_n;
    bus.sym_valid = valid;
    bus.sym_in    = s;
    bus.err_clr   = clr;
    @(posedge CLK);
    model_step(rst_n, valid, s, clr);
    check_en = 1'b1;
    #1;
  endtask

  task automatic check_output();
    check_val("out_valid", 32'(bus.out_valid), 32'(e_valid));
    check_val("code_err",  32'(bus.code_err),  32'(e_code));
    check_val("disp_err",  32'(bus.disp_err),  32'(e_disp));
    check_val("frame_err", 32'(bus.frame_err), 32'(e_frame));
    check_val("in_pkt",    32'(bus.in_pkt),    32'(m_in_pkt));
    check_val("rd_pos",    32'(bus.rd_pos),    32'(m_rd > 0));
    check_val("err_cnt",   32'(bus.err_cnt),   32'(m_cnt));
    if (e_payload) begin
      check_val("out_data", 32'(bus.out_data), 32'(e_data));
      check_val("out_sel",  32'(bus.out_sel),  32'(e_sel));
    end
  endtask

  // Compare DUT against the model every cycle, away from the active edge
  always @(negedge CLK) if (check_en) check_output();

  initial begin
    nRST = 1'b0;
    bus.sym_valid = 1'b0;
    bus.sym_in    = '0;
    bus.err_clr   = 1'b0;
    build_maps();

    $display("[TB] reset state");
    apply_stimulus(0, 0, 10'h000, 0);
    apply_stimulus(0, 1, 10'b1001110100, 0);
    check_val("lit_rst_valid", 32'(bus.out_valid), 32'd0);
    check_val("lit_rst_sel",   32'(bus.out_sel),   32'd9);
    check_val("lit_rst_rd",    32'(bus.rd_pos),    32'd0);
    check_val("lit_rst_inpkt", 32'(bus.in_pkt),    32'd0);

    $display("[TB] packet with data");
    apply_stimulus(1, 1, 10'b0011110100, 0);
    check_val("lit_start_sel",   32'(bus.out_sel), 32'd0);
    check_val("lit_start_inpkt", 32'(bus.in_pkt),  32'd1);
    check_val("lit_start_rd",    32'(bus.rd_pos),  32'd0);
    apply_stimulus(1, 1, 10'b1001110100, 0);
    check_val("lit_d00_data", 32'(bus.out_data), 32'h00);
    check_val("lit_d00_sel",  32'(bus.out_sel),  32'd8);
    check_val("lit_d00_rd",   32'(bus.rd_pos),   32'd0);
    apply_stimulus(1, 1, 10'b1010101010, 0);
    check_val("lit_d21_5", 32'(bus.out_data), 32'hB5);
    apply_stimulus(1, 1, 10'b0011101001, 0);
    check_val("lit_d28_1", 32'(bus.out_data), 32'h3C);
    apply_stimulus(1, 1, 10'b1001111000, 0);
    check_val("lit_d0_7alt", 32'(bus.out_data), 32'hE0);
    check_val("lit_d0_7err", 32'(bus.disp_err), 32'd0);
    apply_stimulus(1, 0, 10'b1111110000, 0);
    check_val("lit_idle_valid", 32'(bus.out_valid), 32'd0);
    check_val("lit_idle_inpkt", 32'(bus.in_pkt),    32'd1);
    apply_stimulus(1, 1, 10'b0011111001, 0);
    check_val("lit_end_sel",   32'(bus.out_sel), 32'd1);
    check_val("lit_end_inpkt", 32'(bus.in_pkt),  32'd0);
    check_val("lit_end_rd",    32'(bus.rd_pos),  32'd1);
    apply_stimulus(1, 1, 10'b1100000101, 0);
    check_val("lit_rs3_sel",  32'(bus.out_sel),  32'd5);
    check_val("lit_rs3_code", 32'(bus.code_err), 32'd0);
    check_val("lit_rs3_disp", 32'(bus.disp_err), 32'd0);

    $display("[TB] framing violations");
    apply_stimulus(1, 1, 10'b0011111001, 0);
    check_val("lit_end_idle_ferr", 32'(bus.frame_err), 32'd1);
    apply_stimulus(1, 1, 10'b1100001011, 0);
    apply_stimulus(1, 1, 10'b1100001011, 0);
    check_val("lit_restart_ferr",  32'(bus.frame_err), 32'd1);
    check_val("lit_restart_inpkt", 32'(bus.in_pkt),    32'd1);
    apply_stimulus(1, 1, 10'b1100000110, 0);

    $display("[TB] disparity errors");
    apply_stimulus(0, 0, 10'h000, 0);
    apply_stimulus(1, 1, 10'b0110000100, 0);
    check_val("lit_disp1_err", 32'(bus.disp_err), 32'd1);
    check_val("lit_disp1_cnt", 32'(bus.err_cnt),  32'd1);
    apply_stimulus(1, 1, 10'b1001110100, 0);
    check_val("lit_disp2_err",   32'(bus.disp_err),  32'd0);
    check_val("lit_disp2_ferr",  32'(bus.frame_err), 32'd1);
    check_val("lit_disp2_valid", 32'(bus.out_valid), 32'd0);

    $display("[TB] invalid code and counter saturation");
    apply_stimulus(1, 1, 10'b1111110000, 0);
    check_val("lit_code_err",  32'(bus.code_err),  32'd1);
    check_val("lit_code_sel",  32'(bus.out_sel),   32'd9);
    check_val("lit_code_data", 32'(bus.out_data),  32'h00);
    check_val("lit_code_valid",32'(bus.out_valid), 32'd1);
    for (int n = 0; n < (1 << ERR_CNT_W) + 3; n++)
      apply_stimulus(1, 1, 10'b1111110000, 0);
    check_val("lit_sat_cnt", 32'(bus.err_cnt), 32'hFF);
    apply_stimulus(1, 1, 10'b1111110000, 1);
    check_val("lit_clr_cnt", 32'(bus.err_cnt), 32'h00);

    $display("[TB] reset mid-packet");
    apply_stimulus(0, 0, 10'h000, 0);
    apply_stimulus(1, 1, 10'b0011110100, 0);
    apply_stimulus(1, 1, 10'b0011110100, 0);
    apply_stimulus(1, 1, 10'b1001111001, 0);
    check_val("lit_pre_rd",  32'(bus.rd_pos),  32'd1);
    check_val("lit_pre_cnt", 32'(bus.err_cnt), 32'd1);
    apply_stimulus(0, 1, 10'b1001110100, 0);
    check_val("lit_mid_inpkt", 32'(bus.in_pkt),    32'd0);
    check_val("lit_mid_rd",    32'(bus.rd_pos),    32'd0);
    check_val("lit_mid_valid", 32'(bus.out_valid), 32'd0);
    check_val("lit_mid_cnt",   32'(bus.err_cnt),   32'd0);
    apply_stimulus(1, 0, 10'h000, 0);

    @(negedge CLK);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
